// File: rtl/sync_event_capture_pkg.sv
// Shared types and constants for the synchronized event capture block.
// DETECT encodings select which filtered edges become events.
package sync_evt_pkg;

  typedef enum logic {IDLE, PEND} evt_state_t;

  localparam logic [1:0] DET_RISE = 2'b01;
  localparam logic [1:0] DET_FALL = 2'b10;
  localparam logic [1:0] DET_BOTH = 2'b11;

endpackage

// File: rtl/sync_event_capture_if.sv
// Event handshake and status bundle between the capture block and control logic.
// The master side produces events; the slave side consumes them and issues clears.
interface sync_evt_if #(
  parameter int CNT_W = 8
);

  logic             evt_valid;
  logic             evt_ready;
  logic             evt_rise;
  logic [CNT_W-1:0] evt_count;
  logic             overflow;
  logic             clr_count;
  logic             clr_ovf;

  modport master (
    output evt_valid,
    output evt_rise,
    output evt_count,
    output overflow,
    input  evt_ready,
    input  clr_count,
    input  clr_ovf
  );

  modport slave (
    input  evt_valid,
    input  evt_rise,
    input  evt_count,
    input  overflow,
    output evt_ready,
    output clr_count,
    output clr_ovf
  );

endinterface

// File: rtl/sync_event_capture_glitch_filter.sv
// Glitch filter: the level only changes after FILT_CYCLES consecutive differing
// samples, and one-cycle rise/fall pulses accompany each change.
module glitch_filter #(
  parameter int FILT_CYCLES = 3
) (
  input  logic clk_a,
  input  logic rst,
  input  logic sig_a_sync,
  output logic level_filt,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [3:0] LAST_CNT = 4'(FILT_CYCLES - 1);

  if (FILT_CYCLES < 1 || FILT_CYCLES > 15) begin : g_bad_filt
    $error("glitch_filter: FILT_CYCLES must be in 1..15");
  end

  logic [3:0] filt_cnt;

  // The count restarts whenever the input agrees with the filtered level, so
  // only an uninterrupted run of differing samples can flip it.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      filt_cnt   <= '0;
      level_filt <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      if (sig_a_sync != level_filt) begin
        if (filt_cnt == LAST_CNT) begin
          filt_cnt   <= '0;
          level_filt <= sig_a_sync;
          rise_pulse <= sig_a_sync;
          fall_pulse <= ~sig_a_sync;
        end else begin
          filt_cnt <= filt_cnt + 4'd1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sync_event_capture.sv
// Filters the synchronized level, turns qualifying edges into a single-entry
// valid/ready event, and tracks a saturating event count plus sticky overflow.
module sync_event_capture
  import sync_evt_pkg::*;
#(
  parameter int         FILT_CYCLES = 3,
  parameter int         CNT_W       = 8,
  parameter logic [1:0] DETECT      = DET_BOTH
) (
  input  logic       clk_a,
  input  logic       rst,
  input  logic       sig_a_sync,
  output logic       level_filt,
  output logic       rise_pulse,
  output logic       fall_pulse,
  sync_evt_if.master evt
);

  if (DETECT == 2'b00) begin : g_bad_detect
    $error("sync_event_capture: DETECT must not be 2'b00");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  evt_state_t       state;
  evt_state_t       state_nxt;
  logic             evt_rise_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic             qe;
  logic             qtype;
  logic             handshake;
  logic             drop;

  glitch_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filter (
    .clk_a      (clk_a),
    .rst        (rst),
    .sig_a_sync (sig_a_sync),
    .level_filt (level_filt),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  assign qe        = (rise_pulse & DETECT[0]) | (fall_pulse & DETECT[1]);
  assign qtype     = rise_pulse;
  assign handshake = evt.evt_valid & evt.evt_ready;
  assign drop      = (state == PEND) & qe & ~handshake;

  always_ff @(posedge clk_a) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A handshake coinciding with a new edge keeps the slot occupied.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (qe) state_nxt = PEND;
      PEND: if (handshake && !qe) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    evt.evt_valid = (state == PEND);
    evt.evt_rise  = evt_rise_q;
    evt.evt_count = count_q;
    evt.overflow  = ovf_q;
  end

  // Event type only reloads when the slot is free or being freed this cycle.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      evt_rise_q <= 1'b0;
    end else if (qe && (state == IDLE || handshake)) begin
      evt_rise_q <= qtype;
    end
  end

  always_ff @(posedge clk_a) begin
    if (rst || evt.clr_count) begin
      count_q <= '0;
    end else if (qe && count_q != CNT_MAX) begin
      count_q <= count_q + 1'b1;
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (evt.clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_event_capture.sv
// Directed bench: one instance detecting both edges, one detecting rises only.
module tb_sync_event_capture;

  logic clk_a = 1'b0;
  logic rst;
  logic sig_a;
  logic sig_b;
  logic level_a, rise_a, fall_a;
  logic level_b, rise_b, fall_b;
  int   total = 0;
  int   bad   = 0;

  sync_evt_if #(.CNT_W(4)) evt_a ();
  sync_evt_if #(.CNT_W(4)) evt_b ();

  sync_event_capture #(.FILT_CYCLES(3), .CNT_W(4), .DETECT(2'b11)) dut_a (
    .clk_a      (clk_a),
    .rst        (rst),
    .sig_a_sync (sig_a),
    .level_filt (level_a),
    .rise_pulse (rise_a),
    .fall_pulse (fall_a),
    .evt        (evt_a.master)
  );

  sync_event_capture #(.FILT_CYCLES(3), .CNT_W(4), .DETECT(2'b01)) dut_b (
    .clk_a      (clk_a),
    .rst        (rst),
    .sig_a_sync (sig_b),
    .level_filt (level_b),
    .rise_pulse (rise_b),
    .fall_pulse (fall_b),
    .evt        (evt_b.master)
  );

  always #5 clk_a = ~clk_a;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_a);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs the A-side outputs: level, rise, fall, valid, evt_rise, overflow, count.
  task automatic check_a(input string tag, input logic l, input logic r, input logic f,
                         input logic v, input logic er, input logic o, input logic [3:0] c);
    check({tag, ".level"}, {7'd0, level_a}, {7'd0, l});
    check({tag, ".rise"},  {7'd0, rise_a},  {7'd0, r});
    check({tag, ".fall"},  {7'd0, fall_a},  {7'd0, f});
    check({tag, ".valid"}, {7'd0, evt_a.evt_valid}, {7'd0, v});
    check({tag, ".erise"}, {7'd0, evt_a.evt_rise},  {7'd0, er});
    check({tag, ".ovf"},   {7'd0, evt_a.overflow},  {7'd0, o});
    check({tag, ".count"}, {4'd0, evt_a.evt_count}, {4'd0, c});
  endtask

  initial begin
    rst = 1'b1; sig_a = 1'b1; sig_b = 1'b0;
    evt_a.evt_ready = 1'b0; evt_a.clr_count = 1'b0; evt_a.clr_ovf = 1'b0;
    evt_b.evt_ready = 1'b0; evt_b.clr_count = 1'b0; evt_b.clr_ovf = 1'b0;

    tick();
    check_a("rst1", 0, 0, 0, 0, 0, 0, 0);
    sig_a = 1'b0;
    tick();
    check_a("rst2", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0; sig_a = 1'b1;
    tick();
    check_a("post_rst", 0, 0, 0, 0, 0, 0, 0);

    // Two-cycle glitch: the post-reset 1 plus one more, then low again.
    tick();
    check_a("glitch_hi", 0, 0, 0, 0, 0, 0, 0);
    sig_a = 1'b0;
    tick(2);
    check_a("glitch_done", 0, 0, 0, 0, 0, 0, 0);

    // Clean rise: level flips on the third edge, event one edge later.
    sig_a = 1'b1;
    tick(2);
    check_a("rise_k1", 0, 0, 0, 0, 0, 0, 0);
    tick();
    check_a("rise_k2", 1, 1, 0, 0, 0, 0, 0);
    tick();
    check_a("rise_k3", 1, 0, 0, 1, 1, 0, 1);

    // Unaccepted fall is dropped.
    sig_a = 1'b0;
    tick(3);
    check_a("fall_pulse", 0, 0, 1, 1, 1, 0, 1);
    tick();
    check_a("drop", 0, 0, 0, 1, 1, 1, 2);
    evt_a.clr_ovf = 1'b1;
    tick();
    evt_a.clr_ovf = 1'b0;
    check_a("clr_ovf", 0, 0, 0, 1, 1, 0, 2);

    // Drop coinciding with clr_ovf: set wins.
    sig_a = 1'b1;
    tick(3);
    check_a("rise2_pulse", 1, 1, 0, 1, 1, 0, 2);
    evt_a.clr_ovf = 1'b1;
    tick();
    evt_a.clr_ovf = 1'b0;
    check_a("set_wins", 1, 0, 0, 1, 1, 1, 3);
    evt_a.clr_ovf = 1'b1;
    tick();
    evt_a.clr_ovf = 1'b0;
    check_a("clr_ovf2", 1, 0, 0, 1, 1, 0, 3);

    // Handshake in the same cycle as a new fall reloads the slot.
    sig_a = 1'b0;
    tick(3);
    check_a("fall2_pulse", 0, 0, 1, 1, 1, 0, 3);
    evt_a.evt_ready = 1'b1;
    tick();
    check_a("hs_plus_qe", 0, 0, 0, 1, 0, 0, 4);
    tick();
    check_a("hs_release", 0, 0, 0, 0, 0, 0, 4);
    tick();
    check_a("ready_idle", 0, 0, 0, 0, 0, 0, 4);
    evt_a.evt_ready = 1'b0;

    // Twenty filtered edges from count 4 saturate at 15.
    for (int e = 0; e < 20; e++) begin
      sig_a = ~sig_a;
      tick(3);
    end
    tick();
    check_a("saturate", 0, 0, 0, 1, 1, 1, 15);

    // clr_count wins over a coincident qualified edge.
    sig_a = 1'b1;
    tick(3);
    check("pre_clr.rise", {7'd0, rise_a}, 8'd1);
    evt_a.clr_count = 1'b1;
    tick();
    evt_a.clr_count = 1'b0;
    check("clr_count", {4'd0, evt_a.evt_count}, 8'd0);
    tick();
    check("clr_count_hold", {4'd0, evt_a.evt_count}, 8'd0);

    // Reset while pending discards the event.
    evt_a.clr_ovf = 1'b1;
    tick();
    evt_a.clr_ovf = 1'b0;
    check_a("pre_rst_pend", 1, 0, 0, 1, 1, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0; sig_a = 1'b0;
    check_a("rst_pend", 0, 0, 0, 0, 0, 0, 0);

    // Rise-only instance: rises become events, falls only pulse.
    sig_b = 1'b1;
    tick(3);
    check("b_rise", {7'd0, rise_b}, 8'd1);
    tick();
    check("b_valid", {7'd0, evt_b.evt_valid}, 8'd1);
    check("b_erise", {7'd0, evt_b.evt_rise}, 8'd1);
    check("b_count1", {4'd0, evt_b.evt_count}, 8'd1);
    evt_b.evt_ready = 1'b1;
    tick();
    evt_b.evt_ready = 1'b0;
    check("b_hs", {7'd0, evt_b.evt_valid}, 8'd0);
    sig_b = 1'b0;
    tick(3);
    check("b_fall", {7'd0, fall_b}, 8'd1);
    tick();
    check("b_no_evt", {7'd0, evt_b.evt_valid}, 8'd0);
    check("b_count_keep", {4'd0, evt_b.evt_count}, 8'd1);
    check("b_ovf", {7'd0, evt_b.overflow}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
